lif_neuron_fetch: RTL and testbench



---
 rtl/snn_pkg.sv | 23 ++
 rtl/lif_neuron_fetch_sat_add.sv | 34 +++
 rtl/lif_neuron_fetch.sv | 177 +++++++++++++++++
 tb/tb_lif_neuron_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared defaults and state encoding for the spiking-neuron fetch blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_pkg;

    // Default weight-memory address width and signed weight width.
    localparam int SNN_ADDR_W   = 4;
    localparam int SNN_DW       = 8;
    // Extra membrane bits above the weight width, so several weights
    // can accumulate before saturation kicks in.
    localparam int SNN_HEADROOM = 4;

    // One timestep walks LEAK -> SCAN/REQ/WAIT per input -> FIRE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAK = 3'd1,
        ST_SCAN = 3'd2,
        ST_REQ  = 3'd3,
        ST_WAIT = 3'd4,
        ST_FIRE = 3'd5
    } state_t;

endpackage

// File: rtl/lif_neuron_fetch_sat_add.sv
// Signed add/subtract of two W-bit operands, clamped to the W-bit signed range.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
module sat_add #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sub,
    output logic signed [W-1:0] sum
);

    localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide;

    // One guard bit catches overflow; clamp toward the sign of the true result.
    always_comb begin
        wide = '0;
        sum  = '0;
        if (sub) begin
            wide = {a[W-1], a} - {b[W-1], b};
        end else begin
            wide = {a[W-1], a} + {b[W-1], b};
        end
        if (wide[W] != wide[W-1]) begin
            sum = wide[W] ? S_MIN : S_MAX;
        end else begin
            sum = wide[W-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron_fetch.sv
// Leaky integrate-and-fire neuron; fetches one weight per active input spike.
// Latency: N_IN+2 cycles per timestep with no spikes, +2 plus responder delay per spike.
// Backpressure: one outstanding weight read; WAIT stalls for w_valid (bounded to
// TIMEOUT cycles when LIF_NEURON_FETCH_TIMEOUT_EN is defined, sets sticky err).
module lif_neuron_fetch
    import snn_pkg::*;
#(
    parameter int ADDR_W     = SNN_ADDR_W,
    parameter int DW         = SNN_DW,
    parameter int N_IN       = 8,
    parameter int BASE_ADDR  = 0,
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [N_IN-1:0]                  spikes_in,
    output logic                             w_req,
    output logic [ADDR_W-1:0]                w_addr,
    input  logic                             w_valid,
    input  logic signed [DW-1:0]             w_data,
    output logic                             spike_out,
    output logic signed [DW+SNN_HEADROOM-1:0] membrane,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int VW    = DW + SNN_HEADROOM;
    localparam int SPK_W = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_IN - 1);
    localparam logic [ADDR_W-1:0] BASE_IDX  = ADDR_W'(BASE_ADDR);

    // Reject configurations the index counter or timeout counter cannot cover.
    if (N_IN < 1 || N_IN > SPK_W) begin : g_bad_n_in
        $error("lif_neuron_fetch: N_IN must be in 1..2**ADDR_W");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("lif_neuron_fetch: TIMEOUT must be at least 1");
    end

    state_t               state;
    logic [SPK_W-1:0]     spk_q;
    logic [ADDR_W-1:0]    idx;
    logic signed [VW-1:0] v_q;

    logic signed [VW-1:0] leak_sh;
    logic signed [VW-1:0] v_leak;
    logic signed [VW-1:0] w_ext;
    logic signed [VW-1:0] v_acc;
    logic signed [31:0]   v_wide;

    assign leak_sh  = v_q >>> LEAK_SHIFT;
    assign w_ext    = {{SNN_HEADROOM{w_data[DW-1]}}, w_data};
    assign v_wide   = {{(32-VW){v_q[VW-1]}}, v_q};
    assign membrane = v_q;

    // Leak path: v - (v >>> LEAK_SHIFT), clamped.
    sat_add #(.W(VW)) u_leak (
        .a   (v_q),
        .b   (leak_sh),
        .sub (1'b1),
        .sum (v_leak)
    );

    // Integrate path: v + sign-extended weight, clamped.
    sat_add #(.W(VW)) u_acc (
        .a   (v_q),
        .b   (w_ext),
        .sub (1'b0),
        .sum (v_acc)
    );

`ifdef LIF_NEURON_FETCH_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0]             tmo_cnt;
`else
    // A silent responder stalls WAIT forever, so there is nothing to flag.
    assign err = 1'b0;
`endif

    // Timestep sequencer; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            spk_q     <= '0;
            idx       <= '0;
            v_q       <= '0;
            w_req     <= 1'b0;
            w_addr    <= '0;
            spike_out <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef LIF_NEURON_FETCH_TIMEOUT_EN
            err       <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            done      <= 1'b0;
            spike_out <= 1'b0;
            w_req     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        spk_q <= SPK_W'(spikes_in);
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_LEAK;
                    end
                end
                ST_LEAK: begin
                    v_q   <= v_leak;
                    state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (spk_q[idx]) begin
                        w_req  <= 1'b1;
                        w_addr <= BASE_IDX + idx;
                        state  <= ST_REQ;
                    end else if (idx == LAST_IDX) begin
                        state <= ST_FIRE;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                ST_REQ: begin
`ifdef LIF_NEURON_FETCH_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_valid) begin
                        v_q <= v_acc;
                        if (idx == LAST_IDX) begin
                            state <= ST_FIRE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ST_SCAN;
                        end
                    end
`ifdef LIF_NEURON_FETCH_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        // Missing weight counts as zero: v is left as is.
                        err <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= ST_FIRE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ST_SCAN;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                ST_FIRE: begin
                    if (v_wide >= THRESH) begin
                        spike_out <= 1'b1;
                        v_q       <= '0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_fetch.sv
// Directed bench for lif_neuron_fetch: default-threshold and never-fire instances.
// Latency: checks cycle-exact done timing against hand-counted schedules.
// Backpressure: a 2-cycle weight responder that can be silenced.
module tb_lif_neuron_fetch;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              start_hi;
    logic [7:0]        spikes_in;
    logic              w_valid;
    logic signed [7:0] w_data;

    logic              w_req, w_req_hi;
    logic [3:0]        w_addr, w_addr_hi;
    logic              spike_out, spike_out_hi;
    logic signed [11:0] membrane, membrane_hi;
    logic              busy, busy_hi;
    logic              done, done_hi;
    logic              err, err_hi;

    logic              resp_vld, stray_vld, resp_en;
    logic signed [7:0] resp_dat, stray_dat;
    logic signed [7:0] wmem [16];
    logic [3:0]        addr_log [16];
    int                req_cnt;

    int total = 0;
    int bad   = 0;

    assign w_valid = resp_vld | stray_vld;
    assign w_data  = resp_vld ? resp_dat : stray_dat;

    lif_neuron_fetch #(
        .ADDR_W(4), .DW(8), .N_IN(8), .BASE_ADDR(0),
        .THRESH(64), .LEAK_SHIFT(2), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .spikes_in(spikes_in),
        .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
        .spike_out(spike_out), .membrane(membrane), .busy(busy),
        .done(done), .err(err)
    );

    lif_neuron_fetch #(
        .ADDR_W(4), .DW(8), .N_IN(8), .BASE_ADDR(0),
        .THRESH(32767), .LEAK_SHIFT(2), .TIMEOUT(15)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .start(start_hi), .spikes_in(spikes_in),
        .w_req(w_req_hi), .w_addr(w_addr_hi), .w_valid(w_valid), .w_data(w_data),
        .spike_out(spike_out_hi), .membrane(membrane_hi), .busy(busy_hi),
        .done(done_hi), .err(err_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight responder: logs every request; answers two cycles later when enabled.
    initial begin
        logic [3:0] a;
        resp_vld = 1'b0;
        resp_dat = '0;
        req_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (w_req || w_req_hi) begin
                a = w_req ? w_addr : w_addr_hi;
                addr_log[req_cnt % 16] = a;
                req_cnt++;
                if (resp_en) begin
                    @(posedge clk);
                    #1;
                    resp_vld = 1'b1;
                    resp_dat = wmem[a];
                    @(posedge clk);
                    #1;
                    resp_vld = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one timestep on the chosen instance; returns at the done cycle.
    task automatic run_step(input bit hi, input logic [7:0] sp, output int cyc,
                            output logic signed [11:0] m_leak,
                            output logic signed [11:0] m_pre,
                            output logic sp_o, output logic signed [11:0] m_done);
        spikes_in = sp;
        if (hi) start_hi = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        start_hi = 1'b0;
        cyc      = 0;
        m_leak   = '0;
        m_pre    = '0;
        while (!(hi ? done_hi : done) && cyc < 200) begin
            m_pre = hi ? membrane_hi : membrane;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) m_leak = hi ? membrane_hi : membrane;
        end
        if (cyc >= 200) begin
            total++;
            bad++;
            $display("FAIL step_timeout: done not seen, waited %0d cycles, limit 200", cyc);
        end
        sp_o   = hi ? spike_out_hi : spike_out;
        m_done = hi ? membrane_hi : membrane;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if ({w_req, spike_out, done, busy, err} !== 5'b0) begin bad++;
            $display("FAIL reset_flags: got %b want 00000", {w_req, spike_out, done, busy, err}); end
        total++; if (w_addr !== 4'd0) begin bad++;
            $display("FAIL reset_addr: got %0d want 0", w_addr); end
        total++; if (membrane !== 12'sd0) begin bad++;
            $display("FAIL reset_membrane: got %0d want 0", membrane); end
        total++; if ({busy_hi, done_hi, membrane_hi} !== 14'b0) begin bad++;
            $display("FAIL reset_hi: got busy=%b done=%b mem=%0d want 0 0 0", busy_hi, done_hi, membrane_hi); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_zero_spikes();
        int cyc; logic signed [11:0] ml, mp, md; logic so; int r0;
        r0 = req_cnt;
        run_step(1'b0, 8'h00, cyc, ml, mp, so, md);
        total++; if (cyc !== 10) begin bad++; $display("FAIL zero_latency: got %0d want 10", cyc); end
        total++; if (req_cnt !== r0) begin bad++; $display("FAIL zero_no_req: got %0d reqs want 0", req_cnt - r0); end
        total++; if (so !== 1'b0) begin bad++; $display("FAIL zero_spike: got %b want 0", so); end
        total++; if (md !== 12'sd0) begin bad++; $display("FAIL zero_membrane: got %0d want 0", md); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_at_done: got %b want 0", busy); end
    endtask

    task automatic test_two_weights();
        int cyc; logic signed [11:0] ml, mp, md; logic so; int r0;
        wmem[0] = 8'sd40; wmem[7] = 8'sd30;
        resp_en = 1'b1;
        r0 = req_cnt;
        run_step(1'b0, 8'h81, cyc, ml, mp, so, md);
        total++; if (req_cnt - r0 !== 2) begin bad++; $display("FAIL w2_req_count: got %0d want 2", req_cnt - r0); end
        total++; if (addr_log[r0 % 16] !== 4'd0) begin bad++; $display("FAIL w2_addr0: got %0d want 0", addr_log[r0 % 16]); end
        total++; if (addr_log[(r0 + 1) % 16] !== 4'd7) begin bad++; $display("FAIL w2_addr1: got %0d want 7", addr_log[(r0 + 1) % 16]); end
        total++; if (cyc !== 14) begin bad++; $display("FAIL w2_latency: got %0d want 14", cyc); end
        total++; if (mp !== 12'sd70) begin bad++; $display("FAIL w2_pre_fire: got %0d want 70", mp); end
        total++; if (so !== 1'b1) begin bad++; $display("FAIL w2_spike: got %b want 1", so); end
        total++; if (md !== 12'sd0) begin bad++; $display("FAIL w2_membrane: got %0d want 0", md); end
    endtask

    task automatic test_leak_fire();
        int cyc; logic signed [11:0] ml, mp, md; logic so;
        wmem[0] = 8'sd60;
        resp_en = 1'b1;
        run_step(1'b0, 8'h01, cyc, ml, mp, so, md);
        total++; if (so !== 1'b0 || md !== 12'sd60) begin bad++;
            $display("FAIL lf_subthresh: got spike=%b mem=%0d want 0 60", so, md); end
        run_step(1'b0, 8'h01, cyc, ml, mp, so, md);
        total++; if (ml !== 12'sd45) begin bad++; $display("FAIL lf_leak: got %0d want 45", ml); end
        total++; if (mp !== 12'sd105) begin bad++; $display("FAIL lf_pre_fire: got %0d want 105", mp); end
        total++; if (so !== 1'b1 || md !== 12'sd0) begin bad++;
            $display("FAIL lf_fire: got spike=%b mem=%0d want 1 0", so, md); end
    endtask

    task automatic test_leak_only();
        int cyc; logic signed [11:0] ml, mp, md; logic so;
        wmem[0] = 8'sd50; wmem[1] = 8'sd50;
        resp_en = 1'b1;
        run_step(1'b1, 8'h03, cyc, ml, mp, so, md);
        total++; if (md !== 12'sd100 || so !== 1'b0) begin bad++;
            $display("FAIL lk_load: got mem=%0d spike=%b want 100 0", md, so); end
        run_step(1'b1, 8'h00, cyc, ml, mp, so, md);
        total++; if (ml !== 12'sd75) begin bad++; $display("FAIL lk_leak: got %0d want 75", ml); end
        total++; if (md !== 12'sd75) begin bad++; $display("FAIL lk_hold: got %0d want 75", md); end
    endtask

    task automatic test_saturate();
        int cyc; logic signed [11:0] ml, mp, md; logic so;
        logic signed [11:0] exp_pos [4];
        logic signed [11:0] exp_neg [4];
        exp_pos = '{12'sd1016, 12'sd1778, 12'sd2047, 12'sd2047};
        exp_neg = '{12'sd512, -12'sd640, -12'sd1504, -12'sd2048};
        do_reset();
        resp_en = 1'b1;
        for (int k = 0; k < 8; k++) wmem[k] = 8'sd127;
        for (int s = 0; s < 4; s++) begin
            run_step(1'b1, 8'hFF, cyc, ml, mp, so, md);
            total++; if (md !== exp_pos[s]) begin bad++;
                $display("FAIL sat_pos[%0d]: got %0d want %0d", s, md, exp_pos[s]); end
        end
        for (int k = 0; k < 8; k++) wmem[k] = -8'sd128;
        for (int s = 0; s < 4; s++) begin
            run_step(1'b1, 8'hFF, cyc, ml, mp, so, md);
            total++; if (md !== exp_neg[s]) begin bad++;
                $display("FAIL sat_neg[%0d]: got %0d want %0d", s, md, exp_neg[s]); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc; int r0;
        stray_dat = 8'sd50;
        stray_vld = 1'b1;
        @(posedge clk);
        #1;
        stray_vld = 1'b0;
        total++; if (membrane !== 12'sd0 || busy !== 1'b0) begin bad++;
            $display("FAIL idle_stray: got mem=%0d busy=%b want 0 0", membrane, busy); end
        r0 = req_cnt;
        spikes_in = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 3) begin
                spikes_in = 8'hFF; start = 1'b1; stray_vld = 1'b1;
            end else if (cyc == 4) begin
                start = 1'b0; stray_vld = 1'b0;
            end
        end
        total++; if (cyc !== 10) begin bad++; $display("FAIL busy_start_latency: got %0d want 10", cyc); end
        total++; if (req_cnt !== r0 || membrane !== 12'sd0) begin bad++;
            $display("FAIL busy_start_ignored: got reqs=%0d mem=%0d want 0 0", req_cnt - r0, membrane); end
        spikes_in = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done); end
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total++; if (cyc !== 10) begin bad++; $display("FAIL b2b_latency: got %0d want 10", cyc); end
    endtask

    task automatic test_timeout();
`ifdef LIF_NEURON_FETCH_TIMEOUT_EN
        int cyc; logic signed [11:0] ml, mp, md; logic so;
        resp_en = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_before: got %b want 0", err); end
        run_step(1'b0, 8'h01, cyc, ml, mp, so, md);
        total++; if (cyc !== 26) begin bad++; $display("FAIL tmo_latency: got %0d want 26", cyc); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", err); end
        total++; if (md !== 12'sd0 || so !== 1'b0) begin bad++;
            $display("FAIL tmo_zero_weight: got mem=%0d spike=%b want 0 0", md, so); end
`else
        int cyc; logic seen;
        resp_en = 1'b0;
        spikes_in = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= done;
        end
        total++; if (busy !== 1'b1 || seen !== 1'b0 || err !== 1'b0) begin bad++;
            $display("FAIL wait_forever: got busy=%b done_seen=%b err=%b want 1 0 0", busy, seen, err); end
        stray_dat = 8'sd5;
        stray_vld = 1'b1;
        @(posedge clk);
        #1;
        stray_vld = 1'b0;
        cyc = 0;
        while (!done && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total++; if (done !== 1'b1 || membrane !== 12'sd5 || err !== 1'b0) begin bad++;
            $display("FAIL late_weight: got done=%b mem=%0d err=%b want 1 5 0", done, membrane, err); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        int cyc; int k; logic seen; logic signed [11:0] ml, mp, md; logic so;
        do_reset();
        wmem[0] = 8'sd20;
        resp_en = 1'b1;
        run_step(1'b0, 8'h01, cyc, ml, mp, so, md);
        total++; if (md !== 12'sd20) begin bad++; $display("FAIL rst_preload: got %0d want 20", md); end
        resp_en = 1'b0;
        spikes_in = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!w_req && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++; if (k >= 20) begin bad++; $display("FAIL rst_wreq_timeout: waited %0d cycles, limit 20", k); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (membrane !== 12'sd15 || busy !== 1'b1) begin bad++;
            $display("FAIL rst_in_wait: got mem=%0d busy=%b want 15 1", membrane, busy); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || membrane !== 12'sd0 || w_req !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL rst_async: got busy=%b mem=%0d req=%b done=%b want 0 0 0 0", busy, membrane, w_req, done); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray_dat = 8'sd33;
        stray_vld = 1'b1;
        @(posedge clk);
        #1;
        stray_vld = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen |= done;
        end
        total++; if (seen !== 1'b0 || busy !== 1'b0 || membrane !== 12'sd0) begin bad++;
            $display("FAIL rst_late_valid: got done_seen=%b busy=%b mem=%0d want 0 0 0", seen, busy, membrane); end
    endtask

    initial begin
        start     = 1'b0;
        start_hi  = 1'b0;
        spikes_in = '0;
        stray_vld = 1'b0;
        stray_dat = '0;
        resp_en   = 1'b0;
        for (int k = 0; k < 16; k++) wmem[k] = '0;
        test_reset();
        test_zero_spikes();
        test_two_weights();
        test_leak_fire();
        test_leak_only();
        test_saturate();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
